// File: rtl/bsg_fpu_class_gen.sv
// Generates a stream of IEEE-754 values, each built to decode to a chosen
// fclass category, cycling through the classes set in a 10-bit mask.
module bsg_fpu_class_gen #(
  parameter int          e_p    = 8,
  parameter int          m_p    = 23,
  parameter logic [31:0] seed_p = 32'h0000_0001
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [9:0]         class_mask_i,
  input  logic [15:0]        count_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [e_p+m_p:0]   data_o,
  output logic [9:0]         class_o,
  output logic               last_o,
  input  logic               ready_i
);

  localparam logic [e_p-1:0] emax_lp = {e_p{1'b1}};

  typedef enum logic {IDLE, EMIT} state_e;

  state_e       state_r, state_n;
  logic [31:0]  lfsr_r;
  logic [9:0]   mask_r;
  logic [15:0]  count_r;
  logic [3:0]   ptr_r;

  logic         accept;
  logic         job_ok;
  logic         hs;

  // Lowest set class bit; mask==0 never reaches EMIT so 0 is a safe default.
  function automatic logic [3:0] lowest_set(input logic [9:0] mask);
    logic [3:0] res;
    res = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (mask[i]) res = 4'(i);
    end
    return res;
  endfunction

  // Next set bit strictly above cur, wrapping; returns cur if it is the only one.
  function automatic logic [3:0] next_set(input logic [9:0] mask, input logic [3:0] cur);
    logic [3:0] res;
    logic       found;
    int         idx;
    res   = cur;
    found = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      idx = (int'(cur) + i) % 10;
      if (!found && mask[idx]) begin
        res   = 4'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign accept = (state_r == IDLE) && v_i;
  assign job_ok = (count_i != 16'd0) && (class_mask_i != 10'd0);
  assign hs     = (state_r == EMIT) && ready_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= IDLE;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: if (accept && job_ok) state_n = EMIT;
      EMIT: if (hs && (count_r == 16'd1)) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Job registers and the LFSR only move on acceptance or an output handshake,
  // which keeps everything frozen under backpressure.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      lfsr_r  <= seed_p;
      mask_r  <= 10'd0;
      count_r <= 16'd0;
      ptr_r   <= 4'd0;
    end else if (accept) begin
      mask_r  <= class_mask_i;
      count_r <= count_i;
      ptr_r   <= lowest_set(class_mask_i);
    end else if (hs) begin
      lfsr_r  <= {lfsr_r[30:0], lfsr_r[31] ^ lfsr_r[21] ^ lfsr_r[1] ^ lfsr_r[0]};
      count_r <= count_r - 16'd1;
      ptr_r   <= next_set(mask_r, ptr_r);
    end
  end

  logic           sign_src;
  logic [e_p-1:0] exp_src;
  logic [m_p-1:0] man_src;
  logic           sign_b;
  logic [e_p-1:0] exp_b;
  logic [m_p-1:0] man_b;

  assign sign_src = lfsr_r[e_p+m_p];
  assign exp_src  = lfsr_r[e_p+m_p-1:m_p];
  assign man_src  = lfsr_r[m_p-1:0];

  // Shape the random fields so the result cannot fall outside the target class.
  always_comb begin
    sign_b = 1'b0;
    exp_b  = '0;
    man_b  = '0;
    case (ptr_r)
      4'd0, 4'd7: begin
        sign_b = (ptr_r == 4'd0);
        exp_b  = emax_lp;
      end
      4'd1, 4'd6: begin
        sign_b = (ptr_r == 4'd1);
        if (exp_src == '0)           exp_b = e_p'(1);
        else if (exp_src == emax_lp) exp_b = emax_lp - e_p'(1);
        else                         exp_b = exp_src;
        man_b = man_src;
      end
      4'd2, 4'd5: begin
        sign_b = (ptr_r == 4'd2);
        man_b  = (man_src == '0) ? m_p'(1) : man_src;
      end
      4'd3: sign_b = 1'b1;
      4'd8: begin
        sign_b = sign_src;
        exp_b  = emax_lp;
        if (man_src[m_p-2:0] == '0) man_b = m_p'(1);
        else                        man_b = {1'b0, man_src[m_p-2:0]};
      end
      4'd9: begin
        sign_b = sign_src;
        exp_b  = emax_lp;
        man_b  = {1'b1, man_src[m_p-2:0]};
      end
      default: begin
        sign_b = 1'b0;
        exp_b  = '0;
        man_b  = '0;
      end
    endcase
  end

  assign ready_o = (state_r == IDLE);
  assign v_o     = (state_r == EMIT);
  assign last_o  = v_o && (count_r == 16'd1);
  assign data_o  = v_o ? {sign_b, exp_b, man_b} : '0;
  assign class_o = v_o ? (10'd1 << ptr_r) : 10'd0;

endmodule
